// File: rtl/mips_seq_ctrl_if.sv
// Instruction-memory fetch handshake between the sequencer and instruction memory.
//   imem_req   : fetch request, held high until imem_ack
//   imem_addr  : fetch address, stable for the whole request
//   imem_ack   : fetch complete; imem_rdata valid in the same cycle
//   imem_rdata : fetched instruction word
// master = sequencer side, slave = memory side.
interface mips_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle sequencer for the non-pipelined MIPS datapath.
// Owns the PC, fetches over the imem handshake into the IR, then steps each instruction
// through DECODE, EXEC and (for writing classes) WB. Resolves branches and JR from datapath
// feedback and traps, stickily, on illegal encodings or a misaligned JR target.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   imem                : fetch handshake (master side)
//   instr               : instruction register
//   alu_src/alu_op/swap_ops/rf_waddr : controls registered on the DECODE->EXEC edge
//   rf_we               : one-cycle register-file write strobe (high during WB)
//   alu_result, rs_data : datapath feedback sampled in EXEC
//   pc, retire, instret : program counter, retire pulse, retired-instruction counter
//   trap                : sticky fault flag
module mips_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_seq_ctrl_if.master        imem,
  output logic [31:0]            instr,
  output logic                   alu_src,
  output logic [1:0]             alu_op,
  output logic                   swap_ops,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            rs_data,
  output logic [31:0]            pc,
  output logic                   retire,
  output logic [31:0]            instret,
  output logic                   trap
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWb, StTrap} state_e;
  typedef enum logic [2:0] {KindWrite, KindBeq, KindBne, KindSlt, KindJr} kind_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpBlt   = 6'b001010;
  localparam logic [5:0] OpBgt   = 6'b001011;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluSlt = 2'b11;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        alu_src_q, alu_src_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        swap_q, swap_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        rf_we_q, rf_we_d;
  logic        retire_q, retire_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;

  // Decoder outputs from the current IR.
  logic        dec_valid;
  kind_e       dec_kind;
  logic        dec_alu_src;
  logic [1:0]  dec_alu_op;
  logic        dec_swap;
  logic [4:0]  dec_waddr;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic        br_taken;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    dec_valid   = 1'b1;
    dec_kind    = KindWrite;
    dec_alu_src = 1'b0;
    dec_alu_op  = AluAdd;
    dec_swap    = 1'b0;
    // rd for R-type, rt otherwise; only meaningful for writing classes.
    dec_waddr   = (instr_q[31:26] == OpRType) ? instr_q[15:11] : instr_q[20:16];
    case (instr_q[31:26])
      OpRType: begin
        case (instr_q[5:0])
          FnAdd:   dec_alu_op = AluAdd;
          FnSub:   dec_alu_op = AluSub;
          FnAnd:   dec_alu_op = AluAnd;
          FnSlt:   dec_alu_op = AluSlt;
          FnJr:    dec_kind   = KindJr;
          default: dec_valid  = 1'b0;
        endcase
      end
      OpAddi:  dec_alu_src = 1'b1;
      OpBeq: begin
        dec_kind   = KindBeq;
        dec_alu_op = AluSub;
      end
      OpBne: begin
        dec_kind   = KindBne;
        dec_alu_op = AluSub;
      end
      OpBlt: begin
        dec_kind   = KindSlt;
        dec_alu_op = AluSlt;
      end
      OpBgt: begin
        // BGT a,b == SLT b,a: datapath swaps operands.
        dec_kind   = KindSlt;
        dec_alu_op = AluSlt;
        dec_swap   = 1'b1;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (kind_q)
      KindBeq: br_taken = (alu_result == 32'd0);
      KindBne: br_taken = (alu_result != 32'd0);
      KindSlt: br_taken = alu_result[0];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    alu_src_d = alu_src_q;
    alu_op_d  = alu_op_q;
    swap_d    = swap_q;
    waddr_d   = waddr_q;
    rf_we_d   = 1'b0;
    retire_d  = 1'b0;
    trap_d    = trap_q;

    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_valid) begin
          kind_d    = dec_kind;
          alu_src_d = dec_alu_src;
          alu_op_d  = dec_alu_op;
          swap_d    = dec_swap;
          waddr_d   = dec_waddr;
          state_d   = StExec;
        end else begin
          trap_d  = 1'b1;
          state_d = StTrap;
        end
      end
      StExec: begin
        case (kind_q)
          KindWrite: begin
            rf_we_d = 1'b1;
            state_d = StWb;
          end
          KindJr: begin
            if (rs_data[1:0] != 2'b00) begin
              trap_d  = 1'b1;
              state_d = StTrap;
            end else begin
              pc_d     = rs_data;
              retire_d = 1'b1;
              state_d  = StFetch;
            end
          end
          default: begin
            pc_d     = br_taken ? br_target : pc_plus4;
            retire_d = 1'b1;
            state_d  = StFetch;
          end
        endcase
      end
      StWb: begin
        pc_d     = pc_plus4;
        retire_d = 1'b1;
        state_d  = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase

    instret_d = retire_d ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      kind_q    <= KindWrite;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      alu_src_q <= 1'b0;
      alu_op_q  <= 2'b00;
      swap_q    <= 1'b0;
      waddr_q   <= 5'd0;
      rf_we_q   <= 1'b0;
      retire_q  <= 1'b0;
      instret_q <= 32'd0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      alu_src_q <= alu_src_d;
      alu_op_q  <= alu_op_d;
      swap_q    <= swap_d;
      waddr_q   <= waddr_d;
      rf_we_q   <= rf_we_d;
      retire_q  <= retire_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

  assign imem.imem_req  = (state_q == StFetch);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign alu_src        = alu_src_q;
  assign alu_op         = alu_op_q;
  assign swap_ops       = swap_q;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = waddr_q;
  assign pc             = pc_q;
  assign retire         = retire_q;
  assign instret        = instret_q;
  assign trap           = trap_q;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
module tb_mips_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        swap_ops;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        trap;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mips_seq_ctrl_if imem_bus ();

  mips_seq_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (imem_bus),
    .instr      (instr),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .swap_ops   (swap_ops),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .alu_result (alu_result),
    .rs_data    (rs_data),
    .pc         (pc),
    .retire     (retire),
    .instret    (instret),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] alu_res;
    logic [31:0] rs;
    int unsigned wt;
    logic        chk_ctrl;
    logic [1:0]  op;
    logic        src;
    logic        swap;
    logic [4:0]  waddr;
    int unsigned we_cnt;
    logic [31:0] exp_pc;
    int unsigned cycles;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic [31:0] word, input logic [31:0] alu_res,
                              input logic [31:0] rs, input int unsigned wt,
                              input logic chk_ctrl, input logic [1:0] op, input logic src,
                              input logic swap, input logic [4:0] waddr,
                              input int unsigned we_cnt, input logic [31:0] exp_pc,
                              input int unsigned cycles);
    vec_t v;
    v.word = word; v.alu_res = alu_res; v.rs = rs; v.wt = wt; v.chk_ctrl = chk_ctrl;
    v.op = op; v.src = src; v.swap = swap; v.waddr = waddr; v.we_cnt = we_cnt;
    v.exp_pc = exp_pc; v.cycles = cycles;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for a request, checks address stability over wt wait cycles,
  // then acks for one cycle. Returns at the negedge of the DECODE cycle.
  task automatic fetch(input logic [31:0] word, input int unsigned wt, input logic [31:0] addr);
    int unsigned guard = 0;
    while (imem_bus.imem_req !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("imem_req_seen", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("imem_addr", imem_bus.imem_addr, addr);
    for (int i = 0; i < int'(wt); i++) begin
      @(negedge clk);
      chk("imem_req_held", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("imem_addr_held", imem_bus.imem_addr, addr);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_instr(input vec_t v, input logic [31:0] fetch_pc,
                          input logic [31:0] exp_instret);
    int unsigned cyc;
    int unsigned we = 0;
    alu_result = v.alu_res;
    rs_data    = v.rs;
    fetch(v.word, v.wt, fetch_pc);
    cyc = v.wt + 1;
    while (retire !== 1'b1 && trap !== 1'b1 && cyc < v.wt + 12) begin
      if (rf_we === 1'b1) we++;
      if (cyc == v.wt + 2 && v.chk_ctrl) begin
        chk("alu_op", {30'd0, alu_op}, {30'd0, v.op});
        chk("alu_src", {31'd0, alu_src}, {31'd0, v.src});
        chk("swap_ops", {31'd0, swap_ops}, {31'd0, v.swap});
        if (v.we_cnt != 0) chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, v.waddr});
      end
      @(negedge clk);
      cyc++;
    end
    chk("cycles", cyc, v.cycles + v.wt);
    chk("rf_we_pulses", we, v.we_cnt);
    chk("pc", pc, v.exp_pc);
    chk("instret", instret, exp_instret);
    chk("instr", instr, v.word);
    chk("trap_clear", {31'd0, trap}, 32'd0);
    if (retire === 1'b1) begin
      @(negedge clk);
      chk("retire_single", {31'd0, retire}, 32'd0);
      chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_trap"}, {31'd0, trap}, 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_bus.imem_req}, 32'd0);
    chk({tag, "_ctrl"}, {24'd0, alu_src, alu_op, swap_ops, rf_we, retire, 2'd0},
        32'd0);
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
  endtask

  initial begin
    logic [31:0] fpc;
    vec_t v;

    tbl[0]  = mk(32'h012A4020, 32'd0, 32'd0,  0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd8, 1, 32'h04, 4);
    tbl[1]  = mk(32'h2128FFFF, 32'd0, 32'd0,  0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd8, 1, 32'h08, 4);
    tbl[2]  = mk(32'h03E00008, 32'd0, 32'h10, 0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 0, 32'h10, 3);
    tbl[3]  = mk(32'h10220003, 32'd0, 32'd0,  0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 0, 32'h20, 3);
    tbl[4]  = mk(32'h03E00008, 32'd0, 32'h10, 0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 0, 32'h10, 3);
    tbl[5]  = mk(32'h10220003, 32'd5, 32'd0,  0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 0, 32'h14, 3);
    tbl[6]  = mk(32'h03E00008, 32'd0, 32'h10, 0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 0, 32'h10, 3);
    tbl[7]  = mk(32'h2C220003, 32'd1, 32'd0,  0, 1'b1, 2'b11, 1'b0, 1'b1, 5'd0, 0, 32'h20, 3);
    tbl[8]  = mk(32'h14220003, 32'd0, 32'd0,  0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 0, 32'h24, 3);
    tbl[9]  = mk(32'h28220003, 32'd1, 32'd0,  0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, 0, 32'h34, 3);
    tbl[10] = mk(32'h2822FFFE, 32'd1, 32'd0,  0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, 0, 32'h30, 3);
    tbl[11] = mk(32'h00221822, 32'd0, 32'd0,  2, 1'b1, 2'b01, 1'b0, 1'b0, 5'd3, 1, 32'h34, 4);
    tbl[12] = mk(32'h00221824, 32'd0, 32'd0,  0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd3, 1, 32'h38, 4);
    tbl[13] = mk(32'h0022182A, 32'd0, 32'd0,  0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd3, 1, 32'h3C, 4);
    tbl[14] = mk(32'h03E00008, 32'd0, 32'hFFFF_FFFC, 0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 0,
                 32'hFFFF_FFFC, 3);
    tbl[15] = mk(32'h012A4020, 32'd0, 32'd0,  0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd8, 1, 32'h00, 4);
    tbl[16] = mk(32'h03E00008, 32'd0, 32'h40, 0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 0, 32'h40, 3);
    tbl[17] = mk(32'h14220003, 32'd7, 32'd0,  0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 0, 32'h50, 3);
    tbl[18] = mk(32'h28220003, 32'd0, 32'd0,  0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, 0, 32'h54, 3);
    tbl[19] = mk(32'h2C220003, 32'd2, 32'd0,  0, 1'b1, 2'b11, 1'b0, 1'b1, 5'd0, 0, 32'h58, 3);

    reset               = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    alu_result          = 32'd0;
    rs_data             = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;

    // Main table: pc chains from one vector to the next.
    fpc = 32'd0;
    for (int i = 0; i < NVEC; i++) begin
      do_instr(tbl[i], fpc, 32'(i + 1));
      fpc = tbl[i].exp_pc;
    end

    // Misaligned JR: trap, pc and instret frozen, no further fetches.
    rs_data = 32'h102;
    fetch(32'h03E00008, 0, 32'h58);
    for (int i = 0; i < 4 && trap !== 1'b1; i++) @(negedge clk);
    chk("jr_trap", {31'd0, trap}, 32'd1);
    chk("jr_trap_pc", pc, 32'h58);
    chk("jr_trap_instret", instret, 32'(NVEC));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("trap_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
      chk("trap_no_we_retire", {30'd0, rf_we, retire}, 32'd0);
      chk("trap_sticky", {31'd0, trap}, 32'd1);
    end

    // Reset clears trap; illegal opcode traps on leaving DECODE.
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset2");
    reset = 1'b1;
    alu_result = 32'd0;
    fetch(32'hFC00_0000, 0, 32'd0);
    @(negedge clk);
    chk("illegal_op_trap", {31'd0, trap}, 32'd1);
    chk("illegal_op_pc", pc, 32'd0);
    chk("illegal_op_instret", instret, 32'd0);
    repeat (3) @(negedge clk);
    chk("illegal_op_no_req", {31'd0, imem_bus.imem_req}, 32'd0);

    // Illegal funct in an R-type word.
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset3");
    reset = 1'b1;
    fetch(32'h0022183F, 0, 32'd0);
    @(negedge clk);
    chk("illegal_fn_trap", {31'd0, trap}, 32'd1);

    // Fetch resumes after reset; 3-cycle ack delay, then reset mid-EXEC.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fetch(32'h2128FFFF, 3, 32'd0);
    @(negedge clk);
    chk("exec_alu_src", {31'd0, alu_src}, 32'd1);
    chk("exec_waddr", {27'd0, rf_waddr}, 32'd8);
    #1 reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    v = mk(32'h012A4020, 32'd0, 32'd0, 1, 1'b1, 2'b00, 1'b0, 1'b0, 5'd8, 1, 32'h04, 4);
    do_instr(v, 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_seq_ctrl.md
# mips_seq_ctrl

Multi-cycle sequencer for the non-pipelined MIPS datapath. It owns the PC, fetches instructions over a req/ack instruction-memory handshake, and latches each one into an instruction register. It steps each instruction through DECODE, EXEC and optional WB, driving the ALU and register-file controls. It resolves branches and JR from datapath feedback and traps on illegal encodings.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; equals pc while imem_req high.
- imem_ack  in  1  fetch complete; imem_rdata valid the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction register (IR).
- alu_src  out  1  1 = sign-extended immediate is the second ALU operand.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 SLT.
- swap_ops  out  1  datapath swaps ALU operands (BGT).
- rf_we  out  1  register-file write strobe, one cycle.
- rf_waddr  out  5  write address: rd for R-type, rt for ADDI.
- alu_result  in  32  datapath ALU output, valid in EXEC.
- rs_data  in  32  register-file value at IR[25:21], valid in EXEC.
- pc  out  32  current program counter.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  32  retired-instruction counter.
- trap  out  1  sticky fault flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP. Reset enters IDLE.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH: imem_req=1 and imem_addr=pc, held until imem_ack. On ack: IR<=imem_rdata, go to DECODE.
- DECODE: classify IR and register alu_src/alu_op/swap_ops/rf_waddr. These outputs stay valid from EXEC through WB.
  - R-type (op 000000): funct 100000/100010/100100/101010 select ADD/SUB/AND/SLT with write; 001000 is JR (no write).
  - ADDI (001000): alu_src=1, ADD, write.
  - BEQ (000100) and BNE (000101): SUB, no write.
  - BLT (001010): SLT, no write.
  - BGT (001011): SLT with swap_ops=1, no write.
  - Any other opcode or funct goes to TRAP on the edge leaving DECODE.
- EXEC: sample alu_result/rs_data and compute next PC. Writing classes go to WB; all others go to FETCH.
  - Default next PC: pc+4.
  - BEQ is taken when alu_result==0. BNE is taken when alu_result!=0. BLT and BGT are taken when alu_result[0]==1.
  - Taken branch: pc+4+(sext(IR[15:0])<<2).
  - JR: rs_data. If rs_data[1:0]!=0, go to TRAP and leave pc unchanged.
- WB: rf_we=1 for exactly one cycle, then pc<=pc+4 and go to FETCH.
- PC arithmetic is modulo 2^32 and wraps silently (0xFFFF_FFFC+4 = 0).
- retire pulses on the edge that updates pc. instret increments on the same edge and wraps at 2^32.
- TRAP: trap=1, imem_req=0, rf_we=0, no retire. Held until reset.

## Timing
- Reset values: pc=RESET_PC, instr=0, trap=0, instret=0. Also zero: imem_req, alu_src, alu_op, swap_ops, rf_we, rf_waddr, retire.
- Reset asynchronously forces all outputs to these values in any state, including mid-fetch. A pending imem_ack is ignored.
- First imem_req: the second clk edge after reset deasserts (IDLE takes one cycle).
- Zero-wait ack latencies: write instructions take 4 cycles (FETCH, DECODE, EXEC, WB); branch, JR and non-taken instructions take 3.
- Each wait cycle on imem_ack adds one cycle. imem_ack outside FETCH is ignored.
- imem_addr is stable for the entire request.
- rf_we and retire are registered, single-cycle pulses. Back-to-back instructions never merge them.
- Controls registered in DECODE change only on the DECODE->EXEC edge.

## Test plan
- Fetch add $8,$9,$10 (0x012A4020) at pc 0 with zero-wait ack -> DECODE gives alu_op=00, alu_src=0, rf_waddr=8. rf_we pulses in the 4th cycle. pc=4, retire=1, instret=1.
- Fetch addi $8,$9,-1 (0x2128FFFF) -> alu_src=1, alu_op=00, rf_waddr=8 (rt). One rf_we pulse, pc advances by 4.
- BEQ with imm=0x0003 at pc 0x10:
  - alu_result=0 -> pc=0x20, no rf_we, 3 cycles.
  - alu_result=5 -> pc=0x14.
  - Repeat as BGT with alu_result=1 -> swap_ops=1, taken.
- JR (funct 001000):
  - rs_data=0x100 -> pc=0x100, no rf_we.
  - rs_data=0x102 -> trap=1, pc unchanged, imem_req stays 0 for 20 cycles.
- Opcode 0x3F -> trap after DECODE; instret and pc unchanged; reset low then high -> trap=0, pc=RESET_PC, fetch resumes.
- imem_ack delayed 3 cycles -> imem_req and imem_addr held 4 cycles. Then assert reset mid-EXEC -> all outputs zero immediately, pc=RESET_PC.
